// File: rtl/alu_acc_ctrl.sv
// Accumulator and two-state sequencer wrapped around an 8-bit add/subtract ALU.
// Takes one operation per handshake, drives the ALU, and writes its result back into acc.
`timescale 1ns/1ps
module alu_acc_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] op_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_s,
  output logic             alu_e,
  input  logic [WIDTH-1:0] alu_w,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             done,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       code_q, code_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      code_q  <= OP_LOAD;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      code_q  <= code_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and writeback; the ALU result is only sampled on the EXEC->IDLE edge.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    code_d  = code_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          b_d     = op_data;
          code_d  = op_code;
          state_d = S_EXEC;
        end
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        case (code_q)
          OP_LOAD: begin
            acc_d   = b_q;
            carry_d = 1'b0;
          end
          OP_ADD: begin
            acc_d   = alu_w;
            carry_d = (alu_w < acc_q);
          end
          OP_SUB: begin
            acc_d   = alu_w;
            carry_d = (acc_q < b_q);
          end
          default: begin
            acc_d   = '0;
            carry_d = 1'b0;
          end
        endcase
      end
    endcase
  end

  assign op_ready = (state_q == S_IDLE);
  assign alu_e    = (state_q == S_EXEC) && ((code_q == OP_ADD) || (code_q == OP_SUB));
  assign alu_s    = (code_q == OP_SUB);
  assign alu_a    = acc_q;
  assign alu_b    = b_q;
  assign acc      = acc_q;
  assign carry    = carry_q;
  assign done     = done_q;
  assign op_count = cnt_q;

endmodule
